demodulate_pos_pi_div2: RTL
===========================

# demodulate_pos_pi_div2

Streaming complex rotator that multiplies sample n by e^{+jπn/2} (that is, by j^n), undoing the −π/2-per-sample frequency shift applied upstream in the chorus effect path. It sits after the chorus modulation stage and returns the complex stream to baseband. It uses a registered valid/ready handshake with a two-entry skid buffer, so it sustains one sample per clock. Rotation is exact, except for negation of the most-negative value, which saturates.

## Interface
- G_DWIDTH, 24, width of each real/imag component, two's complement
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  low = synchronous flush to reset values
- phase_clr  in  1  synchronous; forces the rotation phase to 0
- din_re  in  G_DWIDTH  input real part
- din_im  in  G_DWIDTH  input imaginary part
- din_valid  in  1  input sample valid
- din_ready  out  1  block can accept an input sample
- dout_re  out  G_DWIDTH  rotated real part
- dout_im  out  G_DWIDTH  rotated imaginary part
- dout_valid  out  1  output sample valid
- dout_ready  in  1  downstream accepts the output sample
- phase  out  2  phase counter value to be applied to the next accepted sample
- sat_event  out  1  one-cycle pulse: an accepted sample required saturation

## Operation
- Accept occurs when din_valid & din_ready. Drain occurs when dout_valid & dout_ready.
- Rotation uses the phase value at accept time:
  - 0 → (re, im)
  - 1 → (−im, re)
  - 2 → (−re, −im)
  - 3 → (im, −re)
- Negation saturates: −(−2^(G_DWIDTH−1)) becomes 2^(G_DWIDTH−1)−1. sat_event is asserted the cycle after such an accept.
- Phase counter:
  - Increments by 1 on each accept and wraps 3→0.
  - When phase_clr=1 with no accept, phase becomes 0.
  - When phase_clr=1 together with an accept, that sample uses phase 0 and the counter becomes 1.
- State machine (state_t):
  - SM_INIT: din_ready←1, go to SM_EMPTY.
  - SM_EMPTY: on accept, load the rotated sample into the output register, dout_valid←1, go to SM_ONE.
  - SM_ONE:
    - accept and no drain → load the skid register, din_ready←0, go to SM_FULL.
    - accept and drain → reload the output register, stay in SM_ONE.
    - drain only → dout_valid←0, go to SM_EMPTY.
  - SM_FULL: on drain, output register←skid register, din_ready←1, go to SM_ONE.
- Ordering is strictly preserved. No sample is dropped or duplicated.

## Timing
- Reset values: din_ready=0, dout_valid=0, sat_event=0, phase=0, dout_re/dout_im=0, state=SM_INIT. Skid register contents are invalid.
- din_ready rises 1 cycle after reset is released (SM_INIT).
- Latency is 1 cycle: a sample accepted at edge k is on dout at edge k+1 when the buffer was empty.
- Throughput is 1 sample/clk with dout_ready held high.
- din_ready is registered and depends only on state, never combinationally on dout_ready.
- After dout_ready drops, at most 2 samples are held. din_ready falls the cycle after the second accept.
- dout_re/dout_im/dout_valid are stable while dout_valid=1 and dout_ready=0.
- Reset or enable=0 mid-stream discards both buffered samples. Phase returns to 0, and the first post-recovery sample uses phase 0.

## Structure
- The shared package dsp_rot_pkg holds:
  - state_t (SM_INIT, SM_EMPTY, SM_ONE, SM_FULL)
  - the phase_t 2-bit type
  - the function sat_neg(value, width)
- One combinational sub-module, rot_j_sat, holds the phase-indexed rotation plus saturation and the sat flag. A later modulate/demodulate variant can reuse it with a conjugate select.

## Test plan
- Stream (100,200) four times with dout_ready=1 → (100,200), (−200,100), (−100,−200), (200,−100). phase reads 0,1,2,3 then 0. One output per clock after 1-cycle latency.
- din_re=0x800000, din_im=5 at phase 2 → dout=(0x7FFFFF, −5) and sat_event pulses exactly once.
- dout_ready=0, offer samples A, B, C → A and B accepted, din_ready low from the cycle after B, C held. Release dout_ready → A, B, C out in order with phases 0, 1, 2.
- After 3 accepts, assert phase_clr together with the 4th accept of (1,0) → output (1,0), and phase=1 afterwards.
- Assert async reset in SM_FULL between clock edges → dout_valid and din_ready go low immediately. After release, din_ready=1 after 1 cycle and the next sample uses phase 0.
- Chain the −π/2 modulator into this block with 1000 random non-extreme samples and random backpressure on both sides → output equals input bit-exactly.

Source files
------------

// File: rtl/dsp_rot_pkg.sv
// dsp_rot_pkg: shared types and helpers for the quarter-turn complex rotators
package dsp_rot_pkg;

    typedef enum logic [1:0] {SM_INIT, SM_EMPTY, SM_ONE, SM_FULL} state_t;

    typedef logic [1:0] phase_t;

    // Negate a width-bit two's complement value (sign-extended to 64 bits),
    // clamping -(most negative) to the most positive value.
    function automatic logic signed [63:0] sat_neg(input logic signed [63:0] value, input int unsigned width);
        logic signed [63:0] lim;
        lim = 64'sd1 <<< (width - 1);
        return (value == -lim) ? lim - 64'sd1 : -value;
    endfunction

endpackage

// File: rtl/rot_j_sat.sv
// rot_j_sat: multiply a complex sample by j^phase (or j^-phase when conj) with saturating negation
module rot_j_sat
    import dsp_rot_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         conj,
    input  phase_t       phase,
    input  logic [W-1:0] re,
    input  logic [W-1:0] im,
    output logic [W-1:0] rot_re,
    output logic [W-1:0] rot_im,
    output logic         sat
);

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    phase_t       p;
    logic [W-1:0] n_re;
    logic [W-1:0] n_im;

    // Select the quarter-turn; the sat flag fires only when a most-negative component is negated
    always_comb begin
        p      = conj ? phase_t'(2'd0 - phase) : phase;
        n_re   = W'(sat_neg(64'(signed'(re)), W));
        n_im   = W'(sat_neg(64'(signed'(im)), W));
        rot_re = (p == 2'd0) ? re : (p == 2'd1) ? n_im : (p == 2'd2) ? n_re : im;
        rot_im = (p == 2'd0) ? im : (p == 2'd1) ? re : (p == 2'd2) ? n_im : n_re;
        sat    = (p[1] && re == MIN_VAL) || ((p[1] ^ p[0]) && im == MIN_VAL);
    end

endmodule

// File: rtl/demodulate_pos_pi_div2.sv
// demodulate_pos_pi_div2: rotates sample n by j^n behind a registered two-entry skid buffer
module demodulate_pos_pi_div2
    import dsp_rot_pkg::*;
#(
    parameter int G_DWIDTH = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                phase_clr,
    input  logic [G_DWIDTH-1:0] din_re,
    input  logic [G_DWIDTH-1:0] din_im,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [G_DWIDTH-1:0] dout_re,
    output logic [G_DWIDTH-1:0] dout_im,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [1:0]          phase,
    output logic                sat_event
);

    state_t              state, state_n;
    logic                accept, drain, sat, ready_n, valid_n, sat_n;
    logic [1:0]          use_phase, phase_n;
    logic [G_DWIDTH-1:0] rot_re, rot_im, skid_re, skid_im;
    logic [G_DWIDTH-1:0] out_re_n, out_im_n, skid_re_n, skid_im_n;

    rot_j_sat #(.W(G_DWIDTH)) u_rot (
        .conj   (1'b0),
        .phase  (use_phase),
        .re     (din_re),
        .im     (din_im),
        .rot_re (rot_re),
        .rot_im (rot_im),
        .sat    (sat)
    );

    // Next-state: handshake FSM, phase counter and saturation pulse; enable low flushes everything
    always_comb begin
        accept    = din_valid & din_ready;
        drain     = dout_valid & dout_ready;
        use_phase = phase_clr ? 2'd0 : phase;
        state_n   = state;
        ready_n   = din_ready;
        valid_n   = dout_valid;
        out_re_n  = dout_re;
        out_im_n  = dout_im;
        skid_re_n = skid_re;
        skid_im_n = skid_im;
        phase_n   = accept ? use_phase + 2'd1 : (phase_clr ? 2'd0 : phase);
        sat_n     = accept & sat;
        case (state)
            SM_INIT: begin
                ready_n = 1'b1;
                state_n = SM_EMPTY;
            end
            SM_EMPTY: if (accept) begin
                out_re_n = rot_re;
                out_im_n = rot_im;
                valid_n  = 1'b1;
                state_n  = SM_ONE;
            end
            SM_ONE: if (accept && !drain) begin
                skid_re_n = rot_re;
                skid_im_n = rot_im;
                ready_n   = 1'b0;
                state_n   = SM_FULL;
            end else if (accept) begin
                out_re_n = rot_re;
                out_im_n = rot_im;
            end else if (drain) begin
                valid_n = 1'b0;
                state_n = SM_EMPTY;
            end
            SM_FULL: if (drain) begin
                out_re_n = skid_re;
                out_im_n = skid_im;
                ready_n  = 1'b1;
                state_n  = SM_ONE;
            end
            default: state_n = SM_INIT;
        endcase
        if (!enable) begin
            state_n  = SM_INIT;
            ready_n  = 1'b0;
            valid_n  = 1'b0;
            phase_n  = 2'd0;
            sat_n    = 1'b0;
            out_re_n = '0;
            out_im_n = '0;
        end
    end

    // State register; skid contents are don't-care after reset but cleared for determinism
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SM_INIT;
            din_ready  <= 1'b0;
            dout_valid <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
            skid_re    <= '0;
            skid_im    <= '0;
            phase      <= 2'd0;
            sat_event  <= 1'b0;
        end else begin
            state      <= state_n;
            din_ready  <= ready_n;
            dout_valid <= valid_n;
            dout_re    <= out_re_n;
            dout_im    <= out_im_n;
            skid_re    <= skid_re_n;
            skid_im    <= skid_im_n;
            phase      <= phase_n;
            sat_event  <= sat_n;
        end
    end

endmodule
